// File: rtl/vertex_fetch_sequencer_if.sv
// Bundle of the sequencer's job-control, vertex-RAM read and vertex-output
// signals. Clock and reset are kept as plain ports on the design.
//   job control : i_start, i_base_addr, i_tri_count -> o_busy, o_done
//   RAM read    : o_mem_en, o_mem_addr -> i_mem_rdata (one cycle later)
//   vertex out  : o_vtx_valid/i_vtx_ready handshake, o_vtx_{x,y,z,u,v},
//                 o_vtx_idx, o_vtx_last
// slave  : the sequencer side.
// master : the controller / RAM / consumer side that surrounds it.
interface vertex_fetch_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  i_start;
  logic [ADDR_WIDTH-1:0] i_base_addr;
  logic [15:0]           i_tri_count;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_mem_en;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [DATA_WIDTH-1:0] i_mem_rdata;
  logic                  o_vtx_valid;
  logic                  i_vtx_ready;
  logic [DATA_WIDTH-1:0] o_vtx_x;
  logic [DATA_WIDTH-1:0] o_vtx_y;
  logic [DATA_WIDTH-1:0] o_vtx_z;
  logic [DATA_WIDTH-1:0] o_vtx_u;
  logic [DATA_WIDTH-1:0] o_vtx_v;
  logic [1:0]            o_vtx_idx;
  logic                  o_vtx_last;

  modport slave (
    input  i_start, i_base_addr, i_tri_count, i_mem_rdata, i_vtx_ready,
    output o_busy, o_done, o_mem_en, o_mem_addr, o_vtx_valid,
           o_vtx_x, o_vtx_y, o_vtx_z, o_vtx_u, o_vtx_v, o_vtx_idx, o_vtx_last
  );

  modport master (
    output i_start, i_base_addr, i_tri_count, i_mem_rdata, i_vtx_ready,
    input  o_busy, o_done, o_mem_en, o_mem_addr, o_vtx_valid,
           o_vtx_x, o_vtx_y, o_vtx_z, o_vtx_u, o_vtx_v, o_vtx_idx, o_vtx_last
  );
endinterface

// File: rtl/vertex_fetch_sequencer.sv
// Vertex fetch sequencer: for a job of N triangles it reads 3*N vertices of
// five consecutive words (x,y,z,u,v) from a one-cycle-latency vertex RAM,
// starting at a captured base address (wrapping modulo 2^ADDR_WIDTH), and
// presents each assembled vertex on a valid/ready port together with its
// position in the triangle and a last-of-job flag. One vertex is fetched at
// a time; the next fetch starts on the handshake edge of the previous one.
// Ports:
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : vertex_fetch_sequencer_if.slave (job control, RAM read, vertex out)
module vertex_fetch_sequencer #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  vertex_fetch_sequencer_if.slave        bus
);

  localparam int unsigned CNT_W   = 18;
  localparam int unsigned WORDS_W = 3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_DRAIN   = 3'd2,
    S_PRESENT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                state_q,     state_d;
  logic                  busy_q,      busy_d;
  logic                  done_q,      done_d;
  logic                  mem_en_q,    mem_en_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
  logic                  rd_pend_q,   rd_pend_d;
  logic [WORDS_W-1:0]    issue_cnt_q, issue_cnt_d;
  logic [WORDS_W-1:0]    word_cnt_q,  word_cnt_d;
  logic [CNT_W-1:0]      vtx_left_q,  vtx_left_d;
  logic                  vtx_valid_q, vtx_valid_d;
  logic [DATA_WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d, u_q, u_d, v_q, v_d;
  logic [1:0]            idx_q,       idx_d;
  logic                  last_q,      last_d;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    mem_en_d    = mem_en_q;
    mem_addr_d  = mem_addr_q;
    issue_cnt_d = issue_cnt_q;
    word_cnt_d  = word_cnt_q;
    vtx_left_d  = vtx_left_q;
    vtx_valid_d = vtx_valid_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    u_d         = u_q;
    v_d         = v_q;
    idx_d       = idx_q;
    last_d      = last_q;

    // RAM data is valid the cycle after a read was issued.
    rd_pend_d = mem_en_q;

    // Capture returning words in issue order.
    if (rd_pend_q) begin
      case (word_cnt_q)
        3'd0:    x_d = bus.i_mem_rdata;
        3'd1:    y_d = bus.i_mem_rdata;
        3'd2:    z_d = bus.i_mem_rdata;
        3'd3:    u_d = bus.i_mem_rdata;
        3'd4:    v_d = bus.i_mem_rdata;
        default: ;
      endcase
      word_cnt_d = word_cnt_q + WORDS_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          if (bus.i_tri_count == 16'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d     = S_ISSUE;
            mem_en_d    = 1'b1;
            mem_addr_d  = bus.i_base_addr;
            issue_cnt_d = WORDS_W'(1);
            word_cnt_d  = '0;
            vtx_left_d  = CNT_W'(bus.i_tri_count) * CNT_W'(3);
            idx_d       = 2'd0;
            last_d      = 1'b0;
          end
        end
      end

      // issue_cnt_q counts reads already issued for the current vertex.
      S_ISSUE: begin
        if (issue_cnt_q < WORDS_W'(5)) begin
          mem_addr_d  = mem_addr_q + ADDR_WIDTH'(1);
          issue_cnt_d = issue_cnt_q + WORDS_W'(1);
        end else begin
          mem_en_d = 1'b0;
          state_d  = S_DRAIN;
        end
      end

      // Wait for the v word, which lands one cycle after the last issue.
      S_DRAIN: begin
        if (rd_pend_q && (word_cnt_q == WORDS_W'(4))) begin
          state_d     = S_PRESENT;
          vtx_valid_d = 1'b1;
          last_d      = (vtx_left_q == CNT_W'(1));
        end
      end

      S_PRESENT: begin
        if (vtx_valid_q && bus.i_vtx_ready) begin
          vtx_valid_d = 1'b0;
          vtx_left_d  = vtx_left_q - CNT_W'(1);
          if (vtx_left_q == CNT_W'(1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            // Next vertex follows contiguously, so the address just steps on.
            state_d     = S_ISSUE;
            idx_d       = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
            mem_en_d    = 1'b1;
            mem_addr_d  = mem_addr_q + ADDR_WIDTH'(1);
            issue_cnt_d = WORDS_W'(1);
            word_cnt_d  = '0;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d     = S_IDLE;
        mem_en_d    = 1'b0;
        vtx_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= '0;
      rd_pend_q   <= 1'b0;
      issue_cnt_q <= '0;
      word_cnt_q  <= '0;
      vtx_left_q  <= '0;
      vtx_valid_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      u_q         <= '0;
      v_q         <= '0;
      idx_q       <= 2'd0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_en_q    <= mem_en_d;
      mem_addr_q  <= mem_addr_d;
      rd_pend_q   <= rd_pend_d;
      issue_cnt_q <= issue_cnt_d;
      word_cnt_q  <= word_cnt_d;
      vtx_left_q  <= vtx_left_d;
      vtx_valid_q <= vtx_valid_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      u_q         <= u_d;
      v_q         <= v_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
    end
  end

  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
  assign bus.o_mem_en    = mem_en_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_vtx_valid = vtx_valid_q;
  assign bus.o_vtx_x     = x_q;
  assign bus.o_vtx_y     = y_q;
  assign bus.o_vtx_z     = z_q;
  assign bus.o_vtx_u     = u_q;
  assign bus.o_vtx_v     = v_q;
  assign bus.o_vtx_idx   = idx_q;
  assign bus.o_vtx_last  = last_q;

endmodule

// File: tb/tb_vertex_fetch_sequencer.sv
// Testbench for vertex_fetch_sequencer: a RAM model with one-cycle read
// latency, a job-level reference model that pushes expected read addresses
// and expected vertices into queues, and a monitor that pops and compares
// whatever the design presents.
module tb_vertex_fetch_sequencer;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned RAM_WORDS = 1 << AW;

  typedef struct packed {
    logic [DW-1:0] x, y, z, u, v;
    logic [1:0]    idx;
    logic          last;
  } vtx_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  vertex_fetch_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) vif ();

  vertex_fetch_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (vif.slave)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [RAM_WORDS];
  logic [AW-1:0] exp_addr[$];
  vtx_t          exp_vtx[$];

  int vectors     = 0;
  int miscompares = 0;
  int done_seen   = 0;
  int done_exp    = 0;
  bit ready_rand  = 1'b0;
  bit ready_force = 1'b1;

  // One-cycle-latency vertex RAM.
  always @(posedge clk) begin
    if (vif.o_mem_en) vif.i_mem_rdata <= ram[vif.o_mem_addr];
  end

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: job of tri triangles from base, words addressed modulo RAM size.
  task automatic model_job(input int base, input int tri_n);
    int nv;
    vtx_t e;
    logic [AW-1:0] a;
    nv = 3 * tri_n;
    for (int n = 0; n < nv; n++) begin
      for (int k = 0; k < 5; k++) begin
        a = AW'(base + 5 * n + k);
        exp_addr.push_back(a);
        case (k)
          0: e.x = ram[a];
          1: e.y = ram[a];
          2: e.z = ram[a];
          3: e.u = ram[a];
          default: e.v = ram[a];
        endcase
      end
      e.idx  = 2'(n % 3);
      e.last = (n == nv - 1);
      exp_vtx.push_back(e);
    end
    done_exp++;
  endtask

  // Present start at a negedge; returns just after the sampling edge E0 and
  // scrambles the job inputs, which must no longer matter.
  task automatic start_job(input int base, input int tri_n);
    @(negedge clk);
    vif.i_start     = 1'b1;
    vif.i_base_addr = AW'(base);
    vif.i_tri_count = 16'(tri_n);
    model_job(base, tri_n);
    @(posedge clk);
    #1;
    vif.i_start     = 1'b0;
    vif.i_base_addr = AW'($urandom);
    vif.i_tri_count = 16'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (!vif.o_busy) break;
      n++;
    end
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL wait_idle: still busy after %0d cycles, required idle", budget);
    end
  endtask

  // Consumer ready, changed away from both clock edges.
  initial begin
    vif.i_vtx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      vif.i_vtx_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  // Monitor: reads, presented vertices (every valid cycle, so holds are
  // checked too) and done pulses against the scoreboard queues.
  initial begin
    logic prev_done;
    vtx_t got;
    logic [AW-1:0] a;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (vif.o_mem_en) begin
          if (exp_addr.size() == 0) begin
            chk("mem_read_unexpected", 192'(vif.o_mem_addr), 192'(1) << 191);
          end else begin
            a = exp_addr.pop_front();
            chk("mem_addr", 192'(vif.o_mem_addr), 192'(a));
          end
        end
        if (vif.o_vtx_valid) begin
          got.x = vif.o_vtx_x;  got.y = vif.o_vtx_y;  got.z = vif.o_vtx_z;
          got.u = vif.o_vtx_u;  got.v = vif.o_vtx_v;
          got.idx = vif.o_vtx_idx;  got.last = vif.o_vtx_last;
          if (exp_vtx.size() == 0) begin
            chk("vtx_unexpected", 192'(got), 192'(1) << 191);
          end else begin
            chk("vertex", 192'(got), 192'(exp_vtx[0]));
            if (vif.i_vtx_ready) void'(exp_vtx.pop_front());
          end
        end
        if (vif.o_done) begin
          done_seen++;
          chk("done_after_all_vertices", 192'(exp_vtx.size()), 192'(0));
          chk("done_single_cycle", 192'(prev_done), 192'(0));
        end
        prev_done = vif.o_done;
      end else begin
        prev_done = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    vif.i_start     = 1'b0;
    vif.i_base_addr = '0;
    vif.i_tri_count = '0;
    for (int a = 0; a < RAM_WORDS; a++) ram[a] = DW'(a);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 192'({vif.o_busy, vif.o_done, vif.o_mem_en, vif.o_mem_addr,
        vif.o_vtx_valid, vif.o_vtx_x, vif.o_vtx_y, vif.o_vtx_z, vif.o_vtx_u, vif.o_vtx_v,
        vif.o_vtx_idx, vif.o_vtx_last}), 192'(0));
    rst = 1'b0;

    // Basic job with exact read/valid timing; cycle k is the k-th cycle after E0.
    start_job(0, 1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk($sformatf("mem_en_cycle%0d", k), 192'(vif.o_mem_en), 192'(k <= 5));
      chk($sformatf("valid_cycle%0d", k), 192'(vif.o_vtx_valid), 192'(k == 7));
    end
    wait_idle(200);

    // Consumer stalls on vertex 0.
    ready_force = 1'b0;
    start_job(300, 1);
    repeat (16) @(negedge clk);
    chk("valid_held_during_stall", 192'(vif.o_vtx_valid), 192'(1));
    chk("no_read_during_stall", 192'(vif.o_mem_en), 192'(0));
    ready_force = 1'b1;
    wait_idle(200);

    // Address wrap.
    start_job(1020, 1);
    wait_idle(200);

    // Zero-triangle job.
    start_job(5, 0);
    @(negedge clk);
    chk("tri0_done_cycle1", 192'(vif.o_done), 192'(1));
    chk("tri0_busy_cycle1", 192'(vif.o_busy), 192'(1));
    chk("tri0_mem_en_cycle1", 192'(vif.o_mem_en), 192'(0));
    @(negedge clk);
    chk("tri0_done_cycle2", 192'(vif.o_done), 192'(0));
    chk("tri0_busy_cycle2", 192'(vif.o_busy), 192'(0));

    // Start pulsed mid-job must be ignored.
    start_job(37, 2);
    repeat (10) @(negedge clk);
    vif.i_start = 1'b1;
    vif.i_tri_count = 16'd5;
    vif.i_base_addr = AW'(700);
    @(negedge clk);
    vif.i_start = 1'b0;
    wait_idle(300);

    // Reset while vertex 1 is being issued: job abandoned, no done.
    start_job(200, 2);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (vif.o_vtx_valid && vif.i_vtx_ready) break;
    end
    @(negedge clk);
    chk("issuing_vertex1_before_reset", 192'(vif.o_mem_en), 192'(1));
    #1 rst = 1'b1;
    #1;
    chk("async_reset_outputs", 192'({vif.o_busy, vif.o_done, vif.o_mem_en, vif.o_mem_addr,
        vif.o_vtx_valid, vif.o_vtx_x, vif.o_vtx_y, vif.o_vtx_z, vif.o_vtx_u, vif.o_vtx_v,
        vif.o_vtx_idx, vif.o_vtx_last}), 192'(0));
    exp_vtx.delete();
    exp_addr.delete();
    done_exp--;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    start_job(900, 1);
    wait_idle(200);

    // Randomised jobs, RAM contents and consumer back-pressure.
    for (int a = 0; a < RAM_WORDS; a++) ram[a] = $urandom;
    ready_rand = 1'b1;
    for (int j = 0; j < 10; j++) begin
      start_job(int'($urandom_range(0, RAM_WORDS - 1)), int'($urandom_range(0, 3)));
      wait_idle(2000);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    ready_rand = 1'b0;

    repeat (5) @(negedge clk);
    chk("done_count", 192'(done_seen), 192'(done_exp));
    chk("vertices_outstanding", 192'(exp_vtx.size()), 192'(0));
    chk("reads_outstanding", 192'(exp_addr.size()), 192'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
